run_length_logger: RTL and testbench
====================================

# run_length_logger

Downstream consumer of the two-ones sequence detector. Samples the detector's Mealy output each clock, measures the length of every run of consecutive 1s it flags, and queues one length record per completed run in a small FIFO. Records are drained over a valid/ready handshake by a host or status block. Records that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- LEN_W, 8: width of a length record; lengths saturate at 2^LEN_W-1.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- det_in  in  1  detector output; high in each cycle where the current and previous input bits are both 1.
- run_len  out  LEN_W  length of the head record; 0 when FIFO empty.
- run_valid  out  1  FIFO non-empty.
- run_ready  in  1  consumer accepts the head record when high together with run_valid.
- drop_cnt  out  8  records lost to a full FIFO; saturates at 255.

## Operation
- Meaning of det_in: a run of L >= 2 ones produces L-1 consecutive high cycles on det_in. An isolated 1 (L=1) produces none and is not logged.
- Measurement FSM, two states:
  - IDLE, len=0: on det_in=1, len<=2 and go to RUN. On det_in=0, stay in IDLE.
  - RUN: on det_in=1, len<=min(len+1, 2^LEN_W-1). On det_in=0, push len into the FIFO, set len<=0, and go to IDLE.
- The record value therefore equals L, saturated at 2^LEN_W-1.
- FIFO behaviour:
  - Write pointer and read pointer are log2(DEPTH) bits each and wrap naturally.
  - A count register of log2(DEPTH)+1 bits tracks occupancy.
  - run_valid = (count != 0).
  - run_len = mem[rd_ptr] when valid, else 0.
- Pop: on any edge where run_valid && run_ready, advance rd_ptr.
- Push when not full: write mem[wr_ptr] and advance wr_ptr.
- Push when full:
  - With a pop on the same edge, the push is accepted and count is unchanged.
  - Without a pop, the record is discarded and drop_cnt<=min(drop_cnt+1, 255).
- Push and pop on the same edge with the FIFO empty: not possible, since run_valid=0 means no pop. The pushed record is visible from the next cycle.
- No bypass path: a record never appears on run_len in the same cycle it is pushed.
- The handshake follows standard valid/ready rules. Once run_valid is high, run_len holds stable until it is popped. run_ready may be asserted at any time and is ignored when run_valid=0.

## Timing
- Reset: every edge with reset_n=0 sets the following, and takes priority over all other activity:
  - state=IDLE, len=0, pointers=0, count=0.
  - run_valid=0, run_len=0, drop_cnt=0.
- Reset mid-run: the partial run is discarded and no record is produced. FIFO contents are lost.
- Latency: det_in is sampled low at edge N, ending a run. The record is written at edge N, and run_valid/run_len reflect it from just after edge N. This is 1 cycle after the last high det_in sample.
- Throughput: one push per 2 cycles at most, since a run needs at least 1 high cycle followed by 1 low cycle. The consumer can pop one record per cycle.
- A run still in progress does not count toward FIFO occupancy.
- det_in must be stable before the rising edge. It is combinational from the detector's input bit, so it must meet single-cycle setup; this block adds no synchroniser.

## Test plan
- Single short run: detector input 0,1,1,0 gives det_in high for 1 cycle. Required: exactly one record with run_len=2; run_valid rises 1 cycle after the last det_in high; it pops on the first run_ready=1 and run_valid then falls.
- Backpressure hold: a run of 5 ones (det_in high 4 cycles) with run_ready=0 for 10 cycles. Required: run_len=5 stable and run_valid=1 throughout; a single pop when ready rises.
- Saturation: LEN_W=8 and a run of 300 ones. Required: record 255; len does not wrap; the next run of 3 ones records 3.
- Overflow: DEPTH=4, runs of lengths 2,3,4,5,6 separated by single 0s, run_ready=0. Required: the FIFO holds 2,3,4,5; the 6 is dropped; drop_cnt=1. Draining yields 2,3,4,5 in order, then run_valid=0.
- Full with simultaneous pop: FIFO full, and run_ready=1 on the same edge a run ends. Required: head popped, new record accepted, count stays 4, drop_cnt unchanged.
- Reset mid-run: det_in high 3 cycles, then reset_n=0 for 1 edge while det_in is still high, then det_in low. Required:
  - No record is produced and all outputs are 0 after the reset edge.
  - Because det_in is still high after reset, a fresh run starts at 2 on the next det_in high edge.

Source files
------------

// File: rtl/run_length_logger.sv
// Measures runs of consecutive 1s flagged by the two-ones detector and queues
// one saturated length record per completed run in a small drop-on-full FIFO.
module run_length_logger #(
    parameter int LEN_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             det_in,
    output logic [LEN_W-1:0] run_len,
    output logic             run_valid,
    input  logic             run_ready,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic push;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    // A run closes on the first low det_in sample while measuring
    assign push    = (state == RUN) && !det_in;
    assign pop     = run_valid && run_ready;
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    assign run_valid = (count != '0);
    assign run_len   = run_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (det_in) begin
                        len   <= LEN_W'(2);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (det_in) begin
                        len <= (len == LEN_MAX) ? len : len + LEN_W'(1);
                    end else begin
                        len   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    len   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) begin
            mem[wr_ptr] <= len;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_run_length_logger.sv
// Directed self-checking bench for run_length_logger with hand-computed records.
module tb_run_length_logger;

    logic       clk;
    logic       reset_n;
    logic       det_in;
    logic [7:0] run_len;
    logic       run_valid;
    logic       run_ready;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    run_length_logger #(
        .LEN_W(8),
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .det_in   (det_in),
        .run_len  (run_len),
        .run_valid(run_valid),
        .run_ready(run_ready),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after an edge, so outputs are sampled there too
    task automatic apply_stimulus(input logic det, input logic ready);
        det_in    = det;
        run_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic valid, input int len);
        check_output({tag, "_valid"}, run_valid, valid);
        check_output({tag, "_len"}, run_len, len);
    endtask

    // Run of L ones: L-1 high detector cycles, then one low cycle that closes it
    task automatic send_run(input int l, input logic ready_at_end);
        for (int i = 0; i < l - 1; i++) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, ready_at_end);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        det_in    = 1'b0;
        run_ready = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1);
        check_head("reset", 1'b0, 0);
        check_output("reset_drop", drop_cnt, 0);
        reset_n = 1'b1;

        // Single short run
        apply_stimulus(1'b1, 1'b0);
        check_head("short_inrun", 1'b0, 0);
        apply_stimulus(1'b0, 1'b0);
        check_head("short_rec", 1'b1, 2);
        apply_stimulus(1'b0, 1'b1);
        check_head("short_pop", 1'b0, 0);

        // Backpressure hold
        send_run(5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check_head("hold", 1'b1, 5);
            apply_stimulus(1'b0, 1'b0);
        end
        apply_stimulus(1'b0, 1'b1);
        check_head("hold_pop", 1'b0, 0);

        // Saturation, then a short run after it
        send_run(300, 1'b0);
        check_head("sat", 1'b1, 255);
        apply_stimulus(1'b0, 1'b1);
        check_head("sat_pop", 1'b0, 0);
        send_run(3, 1'b0);
        check_head("after_sat", 1'b1, 3);
        apply_stimulus(1'b0, 1'b1);
        check_head("after_sat_pop", 1'b0, 0);

        // Overflow: fifth record is dropped
        for (int l = 2; l <= 6; l++) send_run(l, 1'b0);
        check_output("ovf_drop", drop_cnt, 1);
        for (int l = 2; l <= 5; l++) begin
            check_head("ovf_drain", 1'b1, l);
            apply_stimulus(1'b0, 1'b1);
        end
        check_head("ovf_empty", 1'b0, 0);

        // Full FIFO with a pop on the edge a run ends
        for (int l = 3; l <= 6; l++) send_run(l, 1'b0);
        check_head("full_head", 1'b1, 3);
        send_run(2, 1'b1);
        check_output("full_pop_drop", drop_cnt, 1);
        check_head("full_pop_head", 1'b1, 4);
        check_head("fp_drain0", 1'b1, 4);
        apply_stimulus(1'b0, 1'b1);
        check_head("fp_drain1", 1'b1, 5);
        apply_stimulus(1'b0, 1'b1);
        check_head("fp_drain2", 1'b1, 6);
        apply_stimulus(1'b0, 1'b1);
        check_head("fp_drain3", 1'b1, 2);
        apply_stimulus(1'b0, 1'b1);
        check_head("fp_empty", 1'b0, 0);

        // Reset mid-run discards the run and the queued record
        send_run(2, 1'b0);
        check_head("pre_reset", 1'b1, 2);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
        reset_n = 1'b0;
        apply_stimulus(1'b1, 1'b0);
        check_head("midrst", 1'b0, 0);
        check_output("midrst_drop", drop_cnt, 0);
        reset_n = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        check_head("post_rst_inrun", 1'b0, 0);
        apply_stimulus(1'b0, 1'b0);
        check_head("post_rst_rec", 1'b1, 2);
        apply_stimulus(1'b0, 1'b1);
        check_head("post_rst_pop", 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
